// File: rtl/fetch_stage.sv
// IF stage of the pipelined LEGv8 core: PC register, next-PC selection and IF/ID register.
// Optional macro HALT_DETECT_EN adds a sticky 'halted' output that freezes fetch on CBZ XZR,#0.
module fetch_stage #(
  parameter int          N      = 64,
  parameter int          ADDR_W = 7,
  parameter logic [31:0] NOP    = 32'h8b1f03ff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [N-1:0]      PCBranch,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic [N-1:0]      IF_ID_pc,
  output logic [31:0]       IF_ID_instr,
  output logic              IF_ID_valid
`ifdef HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  logic [N-1:0] pc;
  logic         hold;

  // Word address wraps modulo the memory size; the PC itself keeps counting.
  assign imem_addr = pc[ADDR_W+1:2];

`ifdef HALT_DETECT_EN
  localparam logic [31:0] HALT_INSTR = 32'hb400001f;

  logic halt_capture;

  assign hold         = stall | halted;
  assign halt_capture = (imem_q == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (PCSrc) begin
      halted <= 1'b0;
    end else if (!hold && halt_capture) begin
      halted <= 1'b1;
    end
  end
`else
  assign hold = stall;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the if/else chain encodes reset > PCSrc > stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (PCSrc) begin
      pc          <= {PCBranch[N-1:2], 2'b00};
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (!hold) begin
      pc          <= pc + N'(4);
      IF_ID_pc    <= pc;
      IF_ID_instr <= imem_q;
      IF_ID_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory word i holds i+1
// (word 5 holds CBZ XZR,#0 when HALT_DETECT_EN is defined).
module tb_fetch_stage;

  localparam int          N      = 64;
  localparam int          ADDR_W = 7;
  localparam logic [31:0] NOP    = 32'h8b1f03ff;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              PCSrc;
  logic [N-1:0]      PCBranch;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic [N-1:0]      IF_ID_pc;
  logic [31:0]       IF_ID_instr;
  logic              IF_ID_valid;
`ifdef HALT_DETECT_EN
  logic              halted;
`endif

  logic [31:0] mem [128];

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage #(.N(N), .ADDR_W(ADDR_W), .NOP(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .PCBranch   (PCBranch),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .IF_ID_pc   (IF_ID_pc),
    .IF_ID_instr(IF_ID_instr),
    .IF_ID_valid(IF_ID_valid)
`ifdef HALT_DETECT_EN
    ,
    .halted     (halted)
`endif
  );

  assign imem_q = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                            input logic valid);
    check({tag, ".pc"}, IF_ID_pc, pc);
    check({tag, ".instr"}, {32'h0, IF_ID_instr}, {32'h0, instr});
    check({tag, ".valid"}, {63'h0, IF_ID_valid}, {63'h0, valid});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i + 1);
`ifdef HALT_DETECT_EN
    mem[5] = 32'hb400001f;
`endif
    reset    = 1'b1;
    stall    = 1'b0;
    PCSrc    = 1'b0;
    PCBranch = '0;
    tick();
    tick();
    check_ifid("reset", 64'h0, NOP, 1'b0);
    check("reset.addr", {57'h0, imem_addr}, 64'd0);

    reset = 1'b0;
    tick();
    check("run1.addr", {57'h0, imem_addr}, 64'd1);
    check_ifid("run1", 64'h0, 32'd1, 1'b1);
    tick();
    check("run2.addr", {57'h0, imem_addr}, 64'd2);
    check_ifid("run2", 64'h4, 32'd2, 1'b1);

    // PC=8: stall two cycles
    stall = 1'b1;
    tick();
    check("stall1.addr", {57'h0, imem_addr}, 64'd2);
    check_ifid("stall1", 64'h4, 32'd2, 1'b1);
    tick();
    check("stall2.addr", {57'h0, imem_addr}, 64'd2);
    check_ifid("stall2", 64'h4, 32'd2, 1'b1);
    stall = 1'b0;
    tick();
    check("release.addr", {57'h0, imem_addr}, 64'd3);
    check_ifid("release", 64'h8, 32'd3, 1'b1);

    // Redirect wins over stall; low bits forced to zero
    PCSrc    = 1'b1;
    stall    = 1'b1;
    PCBranch = 64'h23;
    tick();
    check("redir.addr", {57'h0, imem_addr}, 64'd8);
    check_ifid("redir", 64'h0, NOP, 1'b0);
    PCSrc = 1'b0;
    stall = 1'b0;
    tick();
    check_ifid("redir.next", 64'h20, 32'd9, 1'b1);
    check("redir.next.addr", {57'h0, imem_addr}, 64'd9);

    // Back-to-back redirects: last target wins, IF/ID stays a bubble
    PCSrc    = 1'b1;
    PCBranch = 64'h40;
    tick();
    check("b2b1.addr", {57'h0, imem_addr}, 64'd16);
    check_ifid("b2b1", 64'h0, NOP, 1'b0);
    PCBranch = 64'h1fc;
    tick();
    check("wrap.addr127", {57'h0, imem_addr}, 64'd127);
    check_ifid("b2b2", 64'h0, NOP, 1'b0);
    PCSrc = 1'b0;
    tick();
    check("wrap.addr0", {57'h0, imem_addr}, 64'd0);
    check_ifid("wrap1", 64'h1fc, 32'd128, 1'b1);
    tick();
    check("wrap.addr1", {57'h0, imem_addr}, 64'd1);
    check_ifid("wrap2", 64'h200, 32'd1, 1'b1);

    // Reset dominates redirect and stall
    reset    = 1'b1;
    PCSrc    = 1'b1;
    stall    = 1'b1;
    PCBranch = 64'h80;
    tick();
    check("rst2.addr", {57'h0, imem_addr}, 64'd0);
    check_ifid("rst2", 64'h0, NOP, 1'b0);
    reset = 1'b0;
    PCSrc = 1'b0;
    stall = 1'b0;

`ifdef HALT_DETECT_EN
    check("halt.reset", {63'h0, halted}, 64'd0);
    for (int i = 0; i < 5; i++) tick();
    check("halt.pre", {63'h0, halted}, 64'd0);
    check_ifid("halt.pre", 64'h10, 32'd5, 1'b1);
    tick();
    check("halt.set", {63'h0, halted}, 64'd1);
    check_ifid("halt.set", 64'h14, 32'hb400001f, 1'b1);
    check("halt.addr", {57'h0, imem_addr}, 64'd6);
    tick();
    tick();
    check("halt.hold", {63'h0, halted}, 64'd1);
    check("halt.hold.addr", {57'h0, imem_addr}, 64'd6);
    check_ifid("halt.hold", 64'h14, 32'hb400001f, 1'b1);
    PCSrc    = 1'b1;
    PCBranch = 64'h0;
    tick();
    check("halt.clear", {63'h0, halted}, 64'd0);
    check("halt.clear.addr", {57'h0, imem_addr}, 64'd0);
    check_ifid("halt.clear", 64'h0, NOP, 1'b0);
    PCSrc = 1'b0;
    tick();
    check_ifid("halt.refetch", 64'h0, 32'd1, 1'b1);
`else
    tick();
    check_ifid("post.rst", 64'h0, 32'd1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
